// File: rtl/aes_ctr_keystream_serializer.sv
// Two-entry batch buffer that serializes 512-bit CTR keystream batches into 64-bit words,
// counting batches against the XOF/PRF target. Define KS_BYTE_SWAP_EN for byte-reversed output words.
module aes_ctr_keystream_serializer #(
  parameter int unsigned BATCH_W            = 512,
  parameter int unsigned OUT_W              = 64,
  parameter int unsigned DEPTH              = 2,
  parameter int unsigned XOF_TARGET_BATCHES = 11,
  parameter int unsigned PRF_TARGET_BATCHES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BATCH_W-1:0] in_batch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_last,
  output logic               done
);

  localparam int unsigned WORDS  = BATCH_W / OUT_W;
  localparam int unsigned WIDX_W = $clog2(WORDS);
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [BATCH_W-1:0]   mem_q [DEPTH];
  logic [BATCH_W-1:0]   mem_d [DEPTH];
  logic                 wptr_q, wptr_d;
  logic                 rptr_q, rptr_d;
  logic [1:0]           count_q, count_d;
  logic [WIDX_W-1:0]    widx_q, widx_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic                 mode_q, mode_d;

  logic                 in_fire;
  logic                 out_fire;
  logic                 batch_rel;
  logic                 last_fire;
  logic [3:0]           tgt_last;
  logic [OUT_W-1:0]     rd_word;

`ifdef KS_BYTE_SWAP_EN
  function automatic logic [OUT_W-1:0] byte_rev(input logic [OUT_W-1:0] w);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < OUT_W / 8; b++) begin
      r[b*8 +: 8] = w[OUT_W - 8 - b*8 +: 8];
    end
    return r;
  endfunction
`endif

  assign tgt_last  = mode_q ? 4'(PRF_TARGET_BATCHES - 1) : 4'(XOF_TARGET_BATCHES - 1);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign batch_rel = out_fire & (widx_q == LAST_WIDX);
  assign last_fire = out_last & out_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else if (last_fire) begin
      state_d = S_DONE;
    end
  end

  // Word mux: word 0 is the most significant slice of the batch
  always_comb begin
    rd_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (widx_q == WIDX_W'(w)) begin
        rd_word = mem_q[rptr_q][(WORDS - 1 - w) * OUT_W +: OUT_W];
      end
    end
  end

  // FSM: outputs (derived from registered state only, so no ready pass-through)
  always_comb begin
    done      = (state_q == S_DONE);
    in_ready  = !done && (count_q < 2'(DEPTH));
    out_valid = (count_q != 2'd0) && !done;
    out_last  = out_valid && (widx_q == LAST_WIDX) && (bcnt_q == tgt_last);
`ifdef KS_BYTE_SWAP_EN
    out_data  = byte_rev(rd_word);
`else
    out_data  = rd_word;
`endif
  end

  // Datapath next state; the final word empties the buffer so leftover data is discarded
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    mode_d  = mode_q;
    if (start) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = '0;
      widx_d  = '0;
      bcnt_d  = '0;
      mode_d  = mode;
    end else if (last_fire) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = '0;
      widx_d  = '0;
      bcnt_d  = bcnt_q + 4'd1;
    end else begin
      if (in_fire) begin
        mem_d[wptr_q] = in_batch;
        wptr_d        = ~wptr_q;
      end
      if (out_fire) begin
        widx_d = widx_q + WIDX_W'(1);
      end
      if (batch_rel) begin
        widx_d = '0;
        rptr_d = ~rptr_q;
        bcnt_d = bcnt_q + 4'd1;
      end
      count_d = count_q + {1'b0, in_fire} - {1'b0, batch_rel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_aes_ctr_keystream_serializer.sv
// Directed bench for aes_ctr_keystream_serializer: queue reference model of buffered words,
// checked with immediate assertions each cycle.
module tb_aes_ctr_keystream_serializer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_batch;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  aes_ctr_keystream_serializer #(
    .BATCH_W            (512),
    .OUT_W              (64),
    .DEPTH              (2),
    .XOF_TARGET_BATCHES (11),
    .PRF_TARGET_BATCHES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_batch  (in_batch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] wrd(input int b, input int k);
    logic [7:0] bb, kk;
    bb = b[7:0];
    kk = k[7:0];
    return {8'hA5, bb, kk, 8'h3C, 32'h1357_9BDF + 32'(b * 1000 + k * 7)};
  endfunction

  function automatic logic [511:0] mk_batch(input int b);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[511 - 64*k -: 64] = wrd(b, k);
    return r;
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] w);
`ifdef KS_BYTE_SWAP_EN
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[56 - i*8 +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers nb batches (ids base..), holds out_ready low for 'hold' cycles, optionally random stalls.
  task automatic stream(input int nb, input int base, input int hold, input bit rnd);
    logic [63:0] expq[$];
    logic [63:0] held;
    int total, sent, emitted, cyc, mcount;
    bit stalled, infire, ofire;
    total = nb * 8; sent = 0; emitted = 0; cyc = 0; mcount = 0; stalled = 0; held = '0;
    while (emitted < total && cyc < 3000) begin
      in_valid  = (sent < nb);
      in_batch  = mk_batch(base + sent);
      out_ready = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      chk("in_ready", 64'(in_ready), 64'(mcount < 2));
      chk("out_valid", 64'(out_valid), 64'(mcount != 0));
      if (stalled) chk("stall_hold", out_data, held);
      if (mcount != 0 && expq.size() != 0) begin
        chk("out_data", out_data, expq[0]);
        chk("out_last", 64'(out_last), 64'(emitted == total - 1));
      end
      infire  = (sent < nb) && (mcount < 2);
      ofire   = (mcount != 0) && out_ready;
      stalled = (mcount != 0) && !out_ready;
      if (stalled) held = expq[0];
      @(posedge clk);
      if (ofire) begin
        void'(expq.pop_front());
        emitted++;
        if (emitted % 8 == 0) mcount--;
      end
      if (infire) begin
        for (int k = 0; k < 8; k++) expq.push_back(exp_word(wrd(base + sent, k)));
        sent++;
        mcount++;
      end
      @(negedge clk);
      cyc++;
    end
    #1;
    chk("run_complete", 64'(emitted), 64'(total));
    chk("done_after_last", 64'(done), 64'd1);
    chk("out_valid_after_done", 64'(out_valid), 64'd0);
    chk("in_ready_after_done", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_batch = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PRF run, full rate
    do_start(1'b1);
    stream(2, 1, 0, 1'b0);
    chk("prf_bcnt", 64'(dut.bcnt_q), 64'd2);

    // XOF run, full rate
    do_start(1'b0);
    stream(11, 10, 0, 1'b0);
    chk("xof_bcnt", 64'(dut.bcnt_q), 64'd11);

    // XOF run: consumer held off to fill the buffer, then random stalls
    do_start(1'b0);
    stream(11, 30, 12, 1'b1);

    // start mid-batch together with an offered batch
    do_start(1'b1);
    in_valid = 1'b1; in_batch = mk_batch(50); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_word3", out_data, exp_word(wrd(50, 3)));
    start = 1'b1; mode = 1'b1; in_valid = 1'b1; in_batch = mk_batch(60);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("restart_out_valid", 64'(out_valid), 64'd0);
    chk("restart_in_ready", 64'(in_ready), 64'd1);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_bcnt", 64'(dut.bcnt_q), 64'd0);
    stream(2, 70, 0, 1'b0);

    // byte-order check on a known top word
    do_start(1'b0);
    in_valid = 1'b1; in_batch = {64'h0011_2233_4455_6677, 448'h0}; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("latency_valid", 64'(out_valid), 64'd1);
`ifdef KS_BYTE_SWAP_EN
    chk("first_word", out_data, 64'h7766_5544_3322_1100);
`else
    chk("first_word", out_data, 64'h0011_2233_4455_6677);
`endif

    // asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_data", out_data, 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_done", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_ctr_keystream_serializer.md
# aes_ctr_keystream_serializer

Downstream stage of the 4-core AES-256-CTR engine: captures each 512-bit batch (four 128-bit keystream blocks) through a valid/ready handshake, stores up to two batches, and streams them out as 64-bit words with valid/ready backpressure. It counts emitted batches against the XOF/PRF targets, flags the final word with `out_last`, and raises a sticky `done`. It lets the CTR engine run ahead while the consumer (sampler / PRF user) stalls.

## Interface
- `BATCH_W`, 512, input batch width (4 × 128-bit blocks).
- `OUT_W`, 64, output word width; `BATCH_W/OUT_W` = 8 words per batch.
- `DEPTH`, 2, batch buffer entries.
- `XOF_TARGET_BATCHES`, 11, batches per XOF run (44 blocks).
- `PRF_TARGET_BATCHES`, 2, batches per PRF run (8 blocks).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse: flush buffer, clear counters and `done`, sample `mode`.
- `mode`  in  1  0 = XOF, 1 = PRF; sampled only on `start`.
- `in_valid`  in  1  upstream batch valid.
- `in_ready`  out  1  buffer can accept a batch.
- `in_batch`  in  BATCH_W  keystream batch; block 0 in bits [511:384].
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts word.
- `out_data`  out  OUT_W  keystream word.
- `out_last`  out  1  final word of the run, qualified by `out_valid`.
- `done`  out  1  sticky run complete.

## Operation
- Storage: `DEPTH` × `BATCH_W` registers, 1-bit write and read pointers, 2-bit `count` (0..2), 3-bit word index `widx`, 4-bit batch counter `bcnt`, registered `mode_q`, `done`.
- Write: `in_fire = in_valid & in_ready`. Store in the entry at the write pointer, advance the write pointer, increment `count`.
- `in_ready = !done & (count < DEPTH)`. It depends only on registered state, so no same-cycle pass-through: when full, `in_ready` stays 0 even in a cycle that drains an entry.
- Read: `out_valid = (count != 0) & !done`.
- `out_data` = word `widx` of the read-pointer entry. Word 0 is bits [511:448], word 7 is bits [63:0], so output is MSB-first with block 0 first.
- `out_fire = out_valid & out_ready` increments `widx`.
- On `widx == 7` with `out_fire`: `widx` wraps to 0, the read pointer advances, `count` decrements, and `bcnt` increments.
- Same-cycle write and batch-release: `count` is unchanged and both pointers move.
- Target T is `PRF_TARGET_BATCHES` when `mode_q` = 1, otherwise `XOF_TARGET_BATCHES`.
- `out_last = out_valid & (widx == 7) & (bcnt == T-1)`.
- When the last word fires, `done` is set. `out_valid` and `in_ready` then drop to 0 on the next cycle, and the buffer content is discarded.
- States:
  - IDLE (after reset, before `start`): `in_ready` = 1, all writes accepted, `mode_q` = 0 (XOF).
  - RUN: normal operation.
  - DONE: `done` = 1, everything is held until `start`.
- `start` in any state: clears `count`, both pointers, `widx`, `bcnt`, and `done`; loads `mode_q`; returns to RUN. `start` wins over a simultaneous `in_fire` or `out_fire`, so that data is dropped.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0 (buffer cleared), `out_last` = 0, `done` = 0. Pointers, counters and `mode_q` all reset to 0.
- Latency: a batch accepted at edge N gives `out_valid` = 1 after edge N (one cycle later), first word = `in_batch[511:448]`.
- Throughput: one word per cycle with `out_ready` held high, so 8 cycles per batch.
- With `DEPTH` = 2, upstream is never stalled when the consumer runs at full rate.
- `out_data` is stable while `out_valid & !out_ready`.
- `done` rises one cycle after the final `out_fire`.
- Asynchronous reset mid-run immediately clears all state and outputs to their reset values.

## Configuration
- `KS_BYTE_SWAP_EN`:
  - Defined: each `out_data` word is byte-reversed (byte 0 of the word lands in bits [7:0]), giving little-endian word consumers.
  - Undefined: `out_data` is the word exactly as sliced from the batch.
  - No other behaviour or timing changes.

## Test plan
- Reset, `start` with `mode` = 1, two batches with distinct patterns, `out_ready` = 1 → 16 words in MSB-first order; `out_last` on word 16 only; `done` = 1 one cycle later; `in_ready` = 0.
- `mode` = 0, 11 batches, `out_ready` = 1 → 88 words; `out_last` on word 88; `bcnt` reaches 11; `done` set.
- Hold `out_ready` = 0 and offer 3 batches → first two accepted, `in_ready` = 0 from the cycle after the 2nd accept; third accepted only after 8 words of batch 0 drain.
- Random `out_ready` stalls → `out_data` stable while stalled; no word lost or duplicated versus the reference model.
- `start` pulsed mid-batch together with `in_valid` → buffer empty, `out_valid` = 0, the concurrent batch dropped, a new run begins with `bcnt` = 0.
- Build with `KS_BYTE_SWAP_EN`, batch top word 0x0011223344556677 → first `out_data` = 0x7766554433221100.
